// File: rtl/xbus_pkg.sv
// Shared types and helpers for the X-bus multicast controller.
package xbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Upper bound on columns the helper functions can describe.
    localparam int MAX_COL = 32;

    // Modulo-ncol increment without a divider.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned ncol);
        return (ptr + 32'd1 >= ncol) ? 32'd0 : ptr + 32'd1;
    endfunction

    // Contiguous column mask from lo to hi inclusive, wrapping past ncol-1.
    // lo == hi gives a single bit; the caller never needs an empty range.
    function automatic logic [MAX_COL-1:0] range_mask(input int unsigned lo,
                                                      input int unsigned hi,
                                                      input int unsigned ncol);
        logic [MAX_COL-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_COL; i++) begin
            if (unsigned'(i) < ncol) begin
                if (lo <= hi)
                    m[i[4:0]] = (unsigned'(i) >= lo) && (unsigned'(i) <= hi);
                else
                    m[i[4:0]] = (unsigned'(i) >= lo) || (unsigned'(i) <= hi);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Wrapping counter 0..MOD-1 with synchronous clear (priority) and enable.
module mod_counter
    import xbus_pkg::*;
#(
    parameter int MOD = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count register: clear wins over enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= W'(wrap_inc(32'(cnt), MOD));
    end

endmodule

// File: rtl/xbus_mcast_ctrl.sv
// X-bus multicast controller: streams one activation row onto the shared bus
// with per-column consume/start/end masks from a sliding-window generator.
module xbus_mcast_ctrl
    import xbus_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 3,
    parameter int LEN_W      = 16,
    parameter int KS_W       = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_start,
    input  logic [KS_W-1:0]       cfg_kernel_size,
    input  logic [LEN_W-1:0]      cfg_len,
    output logic                  cfg_err,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic [LEN_W-1:0]      bus_idx,
    output logic                  bus_last,
    output logic [NUM_COL-1:0]    bus_mask,
    output logic [NUM_COL-1:0]    bus_start_mask,
    output logic [NUM_COL-1:0]    bus_end_mask
);

    localparam int PW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

    state_t             state, state_nxt;
    logic [KS_W-1:0]    k_r;
    logic [LEN_W-1:0]   l_r;
    logic [LEN_W-1:0]   n;          // beats accepted so far, index of next beat
    logic [PW-1:0]      lo, hi;     // oldest / newest live output column
    logic [LEN_W-1:0]   k_len, km1, lm1, o_last;
    logic               cfg_ok, start_ok, in_fire, bus_fire;
    logic               hi_adv, lo_adv, ptr_clr;
    logic [MAX_COL-1:0] win_full;
    logic [NUM_COL-1:0] mask_d, start_d, end_d;
    logic               unused_bits;

    assign k_len  = LEN_W'(k_r);
    assign km1    = k_len - LEN_W'(1);
    assign lm1    = l_r - LEN_W'(1);
    assign o_last = l_r - k_len;    // K <= L is guaranteed at config time

    assign cfg_ok   = (cfg_kernel_size != '0)
                   && (int'(cfg_kernel_size) <= NUM_COL)
                   && (int'(cfg_kernel_size) <= int'(cfg_len));
    assign start_ok = (state == IDLE) && cfg_start && !flush && cfg_ok;
    assign in_fire  = in_valid && in_ready;
    assign bus_fire = bus_valid && bus_ready;

    // Pointers track min(n,O) and max(0,n-K+1) modulo NUM_COL for the next beat.
    assign hi_adv  = in_fire && (n < o_last);
    assign lo_adv  = in_fire && (n >= km1);
    assign ptr_clr = flush || start_ok;

    mod_counter #(.MOD(NUM_COL), .W(PW)) u_lo (
        .clk  (clk),
        .rstn (rstn),
        .clr  (ptr_clr),
        .en   (lo_adv),
        .cnt  (lo)
    );

    mod_counter #(.MOD(NUM_COL), .W(PW)) u_hi (
        .clk  (clk),
        .rstn (rstn),
        .clr  (ptr_clr),
        .en   (hi_adv),
        .cnt  (hi)
    );

    assign win_full    = range_mask(32'(lo), 32'(hi), NUM_COL);
    assign unused_bits = ^win_full[MAX_COL-1:NUM_COL];

    // Masks for the beat at index n; start follows hi while outputs remain,
    // end follows lo once the first window has filled.
    always_comb begin
        mask_d  = win_full[NUM_COL-1:0];
        start_d = (n <= o_last) ? (NUM_COL'(1) << hi) : '0;
        end_d   = (n >= km1)    ? (NUM_COL'(1) << lo) : '0;
    end

    // Row config and beat counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_r <= '0;
            l_r <= '0;
            n   <= '0;
        end else if (flush) begin
            n   <= '0;
        end else if (start_ok) begin
            k_r <= cfg_kernel_size;
            l_r <= cfg_len;
            n   <= '0;
        end else if (in_fire) begin
            n   <= n + LEN_W'(1);
        end
    end

    // Config rejection pulse, suppressed by flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cfg_err <= 1'b0;
        else
            cfg_err <= (state == IDLE) && cfg_start && !flush && !cfg_ok;
    end

    // Output register stage; holds while the bus stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_valid      <= 1'b0;
            bus_data       <= '0;
            bus_idx        <= '0;
            bus_last       <= 1'b0;
            bus_mask       <= '0;
            bus_start_mask <= '0;
            bus_end_mask   <= '0;
        end else if (flush) begin
            bus_valid      <= 1'b0;
        end else if (in_fire) begin
            bus_valid      <= 1'b1;
            bus_data       <= in_data;
            bus_idx        <= n;
            bus_last       <= (n == lm1);
            bus_mask       <= mask_d;
            bus_start_mask <= start_d;
            bus_end_mask   <= end_d;
        end else if (bus_fire) begin
            bus_valid      <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state; flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_nxt = RUN;
                RUN:     if (bus_fire && bus_last) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy     = (state == RUN);
        done     = (state == DONE);
        in_ready = (state == RUN) && (!bus_valid || bus_ready) && (n < l_r);
    end

endmodule

// File: tb/tb_xbus_mcast_ctrl.sv
// Randomized bench for xbus_mcast_ctrl against a window-arithmetic model.
module tb_xbus_mcast_ctrl;

    localparam int DW = 16;
    localparam int NC = 3;
    localparam int LW = 16;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_start = 1'b0;
    logic [KW-1:0] cfg_kernel_size = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_err;
    logic          flush = 1'b0;
    logic          busy, done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          bus_valid;
    logic          bus_ready = 1'b0;
    logic [DW-1:0] bus_data;
    logic [LW-1:0] bus_idx;
    logic          bus_last;
    logic [NC-1:0] bus_mask, bus_start_mask, bus_end_mask;

    int n_chk  = 0;
    int n_pass = 0;

    xbus_mcast_ctrl #(.DATA_WIDTH(DW), .NUM_COL(NC), .LEN_W(LW), .KS_W(KW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_start      (cfg_start),
        .cfg_kernel_size(cfg_kernel_size),
        .cfg_len        (cfg_len),
        .cfg_err        (cfg_err),
        .flush          (flush),
        .busy           (busy),
        .done           (done),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready),
        .bus_data       (bus_data),
        .bus_idx        (bus_idx),
        .bus_last       (bus_last),
        .bus_mask       (bus_mask),
        .bus_start_mask (bus_start_mask),
        .bus_end_mask   (bus_end_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    // Reference: outputs o in [max(0,n-K+1), min(n,L-K)], column o mod NC.
    function automatic logic [NC-1:0] m_mask(input int n, input int k, input int l);
        logic [NC-1:0] m;
        int lo_o, hi_o;
        m    = '0;
        lo_o = (n - k + 1 < 0) ? 0 : n - k + 1;
        hi_o = (n < l - k) ? n : l - k;
        for (int o = lo_o; o <= hi_o; o++) m[o % NC] = 1'b1;
        return m;
    endfunction

    function automatic logic [NC-1:0] m_start(input int n, input int k, input int l);
        logic [NC-1:0] m;
        m = '0;
        if (n <= l - k) m[n % NC] = 1'b1;
        return m;
    endfunction

    function automatic logic [NC-1:0] m_end(input int n, input int k);
        logic [NC-1:0] m;
        m = '0;
        if (n >= k - 1) m[(n - k + 1) % NC] = 1'b1;
        return m;
    endfunction

    // Runs one row. pv/pr: percent chance of in_valid/bus_ready.
    // seq>=0 makes data seq,seq+1,...; stall_at holds bus_ready low 4 cycles
    // on that beat; flush_at>=0 aborts once that many beats have left the bus.
    task automatic run_row(input int k, input int l, input int pv, input int pr,
                           input int seq, input int stall_at, input int flush_at);
        logic [DW-1:0] q[$];
        logic [DW-1:0] h_data;
        logic [NC-1:0] h_mask;
        logic [LW-1:0] h_idx;
        logic          hold;
        logic [DW-1:0] exp_d;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int stall_left = 4;
        hold = 1'b0;
        h_data = '0; h_mask = '0; h_idx = '0;
        cfg_kernel_size = KW'(k);
        cfg_len = LW'(l);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk("busy_start", 32'(busy), 32'(1));
        chk("cfg_err_ok", 32'(cfg_err), 32'(0));
        while (got < l && cyc < 4000) begin
            in_valid  = (sent < l) && ($urandom_range(99) < pv);
            in_data   = (seq >= 0) ? DW'(seq + sent) : DW'($urandom);
            bus_ready = (got == stall_at && stall_left > 0) ? 1'b0 : ($urandom_range(99) < pr);
            @(negedge clk);
            if (hold) begin
                chk("hold_data", 32'(bus_data), 32'(h_data));
                chk("hold_mask", 32'(bus_mask), 32'(h_mask));
                chk("hold_idx",  32'(bus_idx),  32'(h_idx));
            end
            chk("in_ready", 32'(in_ready), 32'((!bus_valid || bus_ready) && (sent < l)));
            if (bus_valid && bus_ready) begin
                if (q.size() == 0) begin
                    chk("bus_without_input", 32'(1), 32'(0));
                end else begin
                    exp_d = q.pop_front();
                    chk("data",  32'(bus_data),       32'(exp_d));
                end
                chk("idx",   32'(bus_idx),        32'(got));
                chk("last",  32'(bus_last),       32'(got == l - 1));
                chk("mask",  32'(bus_mask),       32'(m_mask(got, k, l)));
                chk("start", 32'(bus_start_mask), 32'(m_start(got, k, l)));
                chk("end",   32'(bus_end_mask),   32'(m_end(got, k)));
                got++;
            end
            if (bus_valid && !bus_ready) begin
                hold = 1'b1;
                h_data = bus_data; h_mask = bus_mask; h_idx = bus_idx;
                if (got == stall_at) stall_left--;
            end else begin
                hold = 1'b0;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            if (flush_at >= 0 && got == flush_at) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                in_valid = 1'b0;
                chk("flush_bus_valid", 32'(bus_valid), 32'(0));
                chk("flush_busy",      32'(busy),      32'(0));
                chk("flush_done",      32'(done),      32'(0));
                chk("flush_in_ready",  32'(in_ready),  32'(0));
                @(posedge clk); #1;
                chk("flush_done2",     32'(done),      32'(0));
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 4000) chk("row_timeout", 32'(0), 32'(1));
        chk("done_pulse",    32'(done),      32'(1));
        chk("busy_in_done",  32'(busy),      32'(0));
        chk("bus_valid_end", 32'(bus_valid), 32'(0));
        @(posedge clk); #1;
        chk("done_drop",     32'(done),      32'(0));
    endtask

    // Config expected to be rejected.
    task automatic bad_cfg(input int k, input int l);
        cfg_kernel_size = KW'(k);
        cfg_len = LW'(l);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk("cfg_err_pulse", 32'(cfg_err), 32'(1));
        chk("cfg_err_busy",  32'(busy),    32'(0));
        @(posedge clk); #1;
        chk("cfg_err_drop",  32'(cfg_err), 32'(0));
        chk("cfg_err_idle",  32'(busy),    32'(0));
    endtask

    initial begin
        int k, l;
        #12;
        chk("rst_bus_valid", 32'(bus_valid), 32'(0));
        chk("rst_busy",      32'(busy),      32'(0));
        chk("rst_done",      32'(done),      32'(0));
        chk("rst_cfg_err",   32'(cfg_err),   32'(0));
        chk("rst_in_ready",  32'(in_ready),  32'(0));
        chk("rst_mask",      32'(bus_mask),  32'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Reference window, wrap-around, backpressure.
        run_row(3, 5, 100, 100, 10, -1, -1);
        run_row(2, 6, 100, 100, 0, -1, -1);
        run_row(3, 5, 100, 100, 10, 2, -1);

        // Rejected configs.
        bad_cfg(4, 5);
        bad_cfg(3, 2);
        bad_cfg(0, 4);

        // Flush together with a valid start in IDLE: start is ignored.
        cfg_kernel_size = KW'(2); cfg_len = LW'(4);
        cfg_start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy),    32'(0));
        chk("flush_start_err",  32'(cfg_err), 32'(0));

        // Flush mid-row, then a K=1 row.
        run_row(3, 5, 100, 100, 20, -1, 3);
        run_row(1, 2, 100, 100, 40, -1, -1);

        // Async reset mid-row.
        cfg_kernel_size = KW'(2); cfg_len = LW'(6);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0; in_valid = 1'b1; bus_ready = 1'b1; in_data = DW'(7);
        @(posedge clk); @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("arst_bus_valid", 32'(bus_valid), 32'(0));
        chk("arst_busy",      32'(busy),      32'(0));
        chk("arst_in_ready",  32'(in_ready),  32'(0));
        chk("arst_mask",      32'(bus_mask),  32'(0));
        chk("arst_data",      32'(bus_data),  32'(0));
        in_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        run_row(2, 6, 100, 100, 50, -1, -1);

        // Random rows with random valid/ready.
        for (int r = 0; r < 25; r++) begin
            k = $urandom_range(NC, 1);
            l = $urandom_range(14, k);
            run_row(k, l, $urandom_range(100, 30), $urandom_range(100, 30), -1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
